hazard_fwd_ctrl: RTL and testbench



---
 rtl/hazard_fwd_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding control for a 5-stage (F/D/E/M/W) pipeline.
// Tracks {dest reg, result source, Tnew} for the instructions in E, M and W,
// and from those records plus the D-stage operands derives the D-stage stall
// and the forwarding-select codes for the D comparators, E ALU operands and
// M store data.
module hazard_fwd_ctrl #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_D,
    input  logic [REG_W-1:0] rt_D,
    input  logic [1:0]       tuse_rs_D,
    input  logic [1:0]       tuse_rt_D,
    input  logic [REG_W-1:0] a3_D,
    input  logic [1:0]       res_D,
    output logic             stall,
    output logic [2:0]       mcmp1_D,
    output logic [2:0]       mcmp2_D,
    output logic [2:0]       malua_E,
    output logic [2:0]       malub_E,
    output logic [2:0]       mwdm_M
);

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_ALU  = 2'd1;
    localparam logic [1:0] RES_DM   = 2'd2;
    localparam logic [1:0] RES_PC   = 2'd3;

    localparam logic [2:0] SEL_NONE  = 3'd0;
    localparam logic [2:0] SEL_M_ALU = 3'd1;
    localparam logic [2:0] SEL_M_PC  = 3'd2;
    localparam logic [2:0] SEL_W_ALU = 3'd3;
    localparam logic [2:0] SEL_W_DM  = 3'd4;
    localparam logic [2:0] SEL_W_PC  = 3'd5;

    typedef struct packed {
        logic [REG_W-1:0] a3;
        logic [1:0]       res;
        logic [1:0]       tnew;
    } rec_t;

    rec_t             rec_d;
    rec_t             rec_e;
    rec_t             rec_m;
    rec_t             rec_w;
    logic [REG_W-1:0] rs_e;
    logic [REG_W-1:0] rt_e;
    logic [REG_W-1:0] rt_m;
    logic             stall_rs;
    logic             stall_rt;

    // Register 0 is hardwired zero, so it never names a real producer.
    function automatic logic rec_match(input rec_t p, input logic [REG_W-1:0] r);
        return (r != '0) && (p.a3 == r);
    endfunction

    // Moving one stage down the pipe brings the result one cycle closer.
    function automatic rec_t rec_advance(input rec_t p);
        rec_t q;
        q      = p;
        q.tnew = (p.tnew == 2'd0) ? 2'd0 : p.tnew - 2'd1;
        return q;
    endfunction

    // Mux code for a ready producer sitting in M (is_m = 1) or W (is_m = 0).
    // A producer whose value is not ready yet yields no forward.
    function automatic logic [2:0] fwd_code(input rec_t p, input logic is_m);
        logic [2:0] code;
        code = SEL_NONE;
        if (p.tnew == 2'd0) begin
            if (is_m) begin
                case (p.res)
                    RES_ALU: code = SEL_M_ALU;
                    RES_PC:  code = SEL_M_PC;
                    default: code = SEL_NONE;
                endcase
            end else begin
                case (p.res)
                    RES_ALU: code = SEL_W_ALU;
                    RES_DM:  code = SEL_W_DM;
                    RES_PC:  code = SEL_W_PC;
                    default: code = SEL_NONE;
                endcase
            end
        end
        return code;
    endfunction

    // Youngest producer wins: a match in M masks any older match in W.
    function automatic logic [2:0] fwd_mw(input logic [REG_W-1:0] r,
                                          input rec_t pm, input rec_t pw);
        logic [2:0] code;
        code = SEL_NONE;
        if (rec_match(pm, r)) begin
            code = fwd_code(pm, 1'b1);
        end else if (rec_match(pw, r)) begin
            code = fwd_code(pw, 1'b0);
        end
        return code;
    endfunction

    // A producer still in E has nothing to forward yet; it also masks M and W.
    function automatic logic [2:0] fwd_emw(input logic [REG_W-1:0] r, input rec_t pe,
                                           input rec_t pm, input rec_t pw);
        logic [2:0] code;
        code = SEL_NONE;
        if (!rec_match(pe, r)) begin
            code = fwd_mw(r, pm, pw);
        end
        return code;
    endfunction

    // Build the record a D instruction will carry into E (PC link is muxed from M onwards).
    always_comb begin
        rec_d      = '0;
        rec_d.a3   = a3_D;
        rec_d.res  = res_D;
        case (res_D)
            RES_ALU: rec_d.tnew = 2'd1;
            RES_DM:  rec_d.tnew = 2'd2;
            RES_PC:  rec_d.tnew = 2'd1;
            default: rec_d      = '0;
        endcase
        if (res_D == RES_NONE) begin
            rec_d = '0;
        end
    end

    // Stall when a producer in E or M cannot deliver in time for the operand's use.
    always_comb begin
        stall_rs = (rec_match(rec_e, rs_D) && (rec_e.tnew > tuse_rs_D)) ||
                   (rec_match(rec_m, rs_D) && (rec_m.tnew > tuse_rs_D));
        stall_rt = (rec_match(rec_e, rt_D) && (rec_e.tnew > tuse_rt_D)) ||
                   (rec_match(rec_m, rt_D) && (rec_m.tnew > tuse_rt_D));
        stall    = stall_rs || stall_rt;
    end

    // Forward selects for the D comparators, E ALU operands and M store data.
    always_comb begin
        mcmp1_D = fwd_emw(rs_D, rec_e, rec_m, rec_w);
        mcmp2_D = fwd_emw(rt_D, rec_e, rec_m, rec_w);
        malua_E = fwd_mw(rs_e, rec_m, rec_w);
        malub_E = fwd_mw(rt_e, rec_m, rec_w);
        mwdm_M  = rec_match(rec_w, rt_m) ? fwd_code(rec_w, 1'b0) : SEL_NONE;
    end

    // Pipeline of producer records; a stall turns the E entry into a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_e <= '0;
            rec_m <= '0;
            rec_w <= '0;
            rs_e  <= '0;
            rt_e  <= '0;
            rt_m  <= '0;
        end else begin
            rec_w <= rec_advance(rec_m);
            rec_m <= rec_advance(rec_e);
            rt_m  <= rt_e;
            if (stall) begin
                rec_e <= '0;
                rs_e  <= '0;
                rt_e  <= '0;
            end else begin
                rec_e <= rec_d;
                rs_e  <= rs_D;
                rt_e  <= rt_D;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed pipeline scenarios followed by random
// instruction streams, checked against a stage-position model of the pipe.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, a3_D;
    logic [1:0] tuse_rs_D, tuse_rt_D, res_D;
    logic       stall;
    logic [2:0] mcmp1_D, mcmp2_D, malua_E, malub_E, mwdm_M;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: slot 0 = E, 1 = M, 2 = W. Each holds the producer's dest and source.
    int m_a3 [3];
    int m_res[3];
    int m_rs_e, m_rt_e, m_rt_m;

    hazard_fwd_ctrl #(.REG_W(5)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D),
        .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
        .a3_D(a3_D), .res_D(res_D),
        .stall(stall),
        .mcmp1_D(mcmp1_D), .mcmp2_D(mcmp2_D),
        .malua_E(malua_E), .malub_E(malub_E), .mwdm_M(mwdm_M)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stage (0=E,1=M,2=W) from which a result can first be forwarded.
    function automatic int ready_stage(input int res);
        case (res)
            1: return 1;
            2: return 2;
            3: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int tnew_of(input int s);
        int t;
        t = ready_stage(m_res[s]) - s;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic int exp_sel(input int r, input int first);
        for (int s = first; s < 3; s++) begin
            if (r != 0 && m_a3[s] == r) begin
                if (s == 0 || tnew_of(s) != 0) return 0;
                if (s == 1) return (m_res[s] == 1) ? 1 : (m_res[s] == 3) ? 2 : 0;
                return (m_res[s] == 1) ? 3 : (m_res[s] == 2) ? 4 : 5;
            end
        end
        return 0;
    endfunction

    function automatic int exp_stall();
        for (int s = 0; s < 2; s++) begin
            if (rs_D != 0 && m_a3[s] == rs_D && tnew_of(s) > tuse_rs_D) return 1;
            if (rt_D != 0 && m_a3[s] == rt_D && tnew_of(s) > tuse_rt_D) return 1;
        end
        return 0;
    endfunction

    task automatic check_model();
        chk("stall",   stall,   exp_stall());
        chk("mcmp1_D", mcmp1_D, exp_sel(rs_D, 0));
        chk("mcmp2_D", mcmp2_D, exp_sel(rt_D, 0));
        chk("malua_E", malua_E, exp_sel(m_rs_e, 1));
        chk("malub_E", malub_E, exp_sel(m_rt_e, 1));
        chk("mwdm_M",  mwdm_M,  exp_sel(m_rt_m, 2));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_sel"}, {mcmp1_D, mcmp2_D, malua_E, malub_E, mwdm_M}, 0);
    endtask

    task automatic drv(input int rs, input int rt, input int trs, input int trt,
                       input int a3, input int res);
        reset     = 1'b0;
        rs_D      = 5'(rs);
        rt_D      = 5'(rt);
        tuse_rs_D = 2'(trs);
        tuse_rt_D = 2'(trt);
        a3_D      = 5'(a3);
        res_D     = 2'(res);
        #1;
    endtask

    // Advance one clock, moving the model the same way the pipeline should.
    task automatic tick();
        int st;
        st = exp_stall();
        @(posedge clk);
        if (reset) begin
            for (int s = 0; s < 3; s++) begin
                m_a3[s] = 0;
                m_res[s] = 0;
            end
            m_rs_e = 0; m_rt_e = 0; m_rt_m = 0;
        end else begin
            m_a3[2] = m_a3[1]; m_res[2] = m_res[1];
            m_a3[1] = m_a3[0]; m_res[1] = m_res[0];
            m_rt_m  = m_rt_e;
            if (st != 0) begin
                m_a3[0] = 0; m_res[0] = 0; m_rs_e = 0; m_rt_e = 0;
            end else begin
                m_res[0] = res_D;
                m_a3[0]  = (res_D == 0) ? 0 : int'(a3_D);
                m_rs_e   = rs_D;
                m_rt_e   = rt_D;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        drv(0, 0, 3, 3, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            m_a3[s] = 0;
            m_res[s] = 0;
        end
        m_rs_e = 0; m_rt_e = 0; m_rt_m = 0;
        @(negedge clk);
        do_reset(2);
        check_zero("rst_init");

        // Reset mid-stream with a load in E.
        drv(0, 0, 3, 3, 9, 2); tick();
        drv(9, 9, 0, 0, 0, 0);
        chk("rst_pre_stall", stall, 1);
        reset = 1'b1; tick(); tick();
        drv(9, 9, 0, 0, 0, 0);
        check_zero("rst_mid");
        check_model();

        // ALU result feeding a branch compare.
        drv(0, 0, 3, 3, 8, 1); tick();
        drv(8, 0, 0, 3, 0, 0);
        chk("alu_br_stall", stall, 1); check_model(); tick();
        drv(8, 0, 0, 3, 0, 0);
        chk("alu_br_stall2", stall, 0);
        chk("alu_br_mcmp1", mcmp1_D, 1); check_model(); tick();

        // Load-use on rt consumed in E.
        do_reset(1);
        drv(0, 0, 3, 3, 9, 2); tick();
        drv(0, 9, 3, 1, 0, 0);
        chk("ldu_stall", stall, 1); check_model(); tick();
        drv(0, 9, 3, 1, 0, 0);
        chk("ldu_stall2", stall, 0); check_model(); tick();
        drv(0, 0, 3, 3, 0, 0);
        chk("ldu_malub", malub_E, 4); check_model(); tick();

        // Load feeding store data.
        do_reset(1);
        drv(0, 0, 3, 3, 9, 2); tick();
        drv(0, 9, 3, 2, 0, 0);
        chk("ldst_stall", stall, 0); check_model(); tick();
        drv(0, 0, 3, 3, 0, 0); check_model(); tick();
        drv(0, 0, 3, 3, 0, 0);
        chk("ldst_mwdm", mwdm_M, 4); check_model(); tick();

        // Younger M producer beats older W producer; $0 never matches.
        do_reset(1);
        drv(0, 0, 3, 3, 5, 2); tick();
        drv(0, 0, 3, 3, 5, 1); tick();
        drv(5, 0, 1, 3, 0, 1);
        chk("prio_stall", stall, 0); check_model(); tick();
        drv(0, 0, 0, 0, 0, 1);
        chk("prio_malua", malua_E, 1); check_model(); tick();
        drv(0, 0, 0, 0, 0, 0); tick(); tick();
        drv(0, 0, 0, 0, 0, 0);
        check_zero("zero_reg"); check_model();

        // jal link register consumed by a branch.
        do_reset(1);
        drv(0, 0, 3, 3, 31, 3); tick();
        drv(31, 0, 0, 3, 0, 0);
        chk("jal_stall", stall, 1); check_model(); tick();
        drv(31, 0, 0, 3, 0, 0);
        chk("jal_mcmp1_m", mcmp1_D, 2); check_model(); tick();
        drv(31, 0, 0, 3, 0, 0);
        chk("jal_mcmp1_w", mcmp1_D, 5); check_model(); tick();

        // Random instruction streams over a small register set.
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            drv($urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 7), $urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) reset = 1'b1;
            check_model();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
